// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer for the dual-clock system. Lives in the always-on reference
// clock domain and drives the per-domain reset synchronizers. Domain reset
// requests are released one at a time in index order; each release waits for
// the previous domain's acknowledgement (or a timeout) and a minimum gap.
//
// Ports:
//   CLK         controller clock
//   RST         asynchronous, active-low reset
//   SW_RST_REQ  soft re-reset request, level-sampled on CLK
//   DOM_ACK     per-domain "reset released" ack, already synchronous to CLK
//   BLK_RST_N   per-domain reset request, active-low, registered
//   RST_DONE    all domains released, sequence complete
//   BUSY        sequence in progress
//   ERR         sticky: at least one ack timeout in the current sequence
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOM_ACK,
    output logic [NUM_DOMAINS-1:0] BLK_RST_N,
    output logic                   RST_DONE,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DOMAINS);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic                   r_armed;
    logic [NUM_DOMAINS-1:0] r_blkRstN;
    logic                   r_rstDone;
    logic                   r_busy;
    logic                   r_err;

    state_t                 w_nextState;
    logic [CW-1:0]          w_nextCnt;
    logic [IW-1:0]          w_nextIdx;
    logic                   w_timeoutHit;
    logic                   w_ackOk;
    logic                   w_timeoutNow;
    logic [NUM_DOMAINS-1:0] w_nextBlkRstN;
    logic                   w_nextRstDone;
    logic                   w_nextBusy;
    logic                   w_nextErr;

    // The ack only counts once the minimum gap since the last release is met;
    // acks of other domains are never looked at.
    assign w_ackOk      = (r_cnt >= GAP_LAST) && DOM_ACK[r_idx];
    assign w_timeoutNow = (r_cnt == TIMEOUT_LAST);

    // State register. Outputs are registered here too, loaded from the
    // output-decode process, so no input reaches an output combinationally.
    // r_armed marks that the first edge after RST has been seen: that edge
    // only loads HOLD, which is why a power-up release lands one edge later
    // than a release following a soft request.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_armed   <= 1'b0;
            r_blkRstN <= '0;
            r_rstDone <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_idx     <= w_nextIdx;
            r_armed   <= 1'b1;
            r_blkRstN <= w_nextBlkRstN;
            r_rstDone <= w_nextRstDone;
            r_busy    <= w_nextBusy;
            r_err     <= w_nextErr;
        end
    end

    // Next-state logic. A soft request beats everything; inside WAIT a valid
    // ack beats the timeout, so the timeout flag is raised only without one.
    // The counter is bounded by HOLD_LAST / TIMEOUT_LAST and never wraps.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextIdx    = r_idx;
        w_timeoutHit = 1'b0;
        if (SW_RST_REQ) begin
            w_nextState = ST_HOLD;
            w_nextCnt   = '0;
            w_nextIdx   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (!r_armed) begin
                        w_nextCnt = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_nextState = ST_WAIT;
                        w_nextCnt   = '0;
                        w_nextIdx   = '0;
                    end else begin
                        w_nextCnt = r_cnt + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (w_ackOk || w_timeoutNow) begin
                        w_timeoutHit = !w_ackOk;
                        w_nextCnt    = '0;
                        if (r_idx == LAST_IDX) begin
                            w_nextState = ST_DONE;
                        end else begin
                            w_nextIdx = r_idx + IW'(1);
                        end
                    end else begin
                        w_nextCnt = r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    w_nextCnt = '0;
                end
                default: begin
                    w_nextState = ST_HOLD;
                    w_nextCnt   = '0;
                    w_nextIdx   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state. In WAIT(idx) domains 0..idx are
    // released, which gives strict index-order release for free.
    always_comb begin
        w_nextBlkRstN = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_nextBlkRstN[i] = (w_nextState == ST_DONE) ||
                               ((w_nextState == ST_WAIT) && (w_nextIdx >= IW'(i)));
        end
        w_nextRstDone = (w_nextState == ST_DONE);
        w_nextBusy    = (w_nextState != ST_DONE);
        w_nextErr     = SW_RST_REQ ? 1'b0 : (r_err | w_timeoutHit);
    end

    assign BLK_RST_N = r_blkRstN;
    assign RST_DONE  = r_rstDone;
    assign BUSY      = r_busy;
    assign ERR       = r_err;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Self-checking bench for rst_seq_ctrl with default parameters. The stimulus
// process queues every expected output change (edge number + value); the
// monitor process pops an entry each time the DUT outputs change and compares.
// Value packing: {BLK_RST_N[2:0], RST_DONE, BUSY, ERR}.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    logic       CLK;
    logic       RST;
    logic       SW_RST_REQ;
    logic [2:0] DOM_ACK;
    logic [2:0] BLK_RST_N;
    logic       RST_DONE;
    logic       BUSY;
    logic       ERR;

    typedef struct {
        int         at;
        logic [5:0] val;
    } exp_t;

    exp_t       q[$];
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;
    logic [5:0] last  = 6'b000010;

    localparam logic [5:0] V_HOLD   = 6'b000010;
    localparam logic [5:0] V_REL0   = 6'b001010;
    localparam logic [5:0] V_REL1   = 6'b011010;
    localparam logic [5:0] V_REL2   = 6'b111010;
    localparam logic [5:0] V_DONE   = 6'b111100;
    localparam logic [5:0] V_TOREL2 = 6'b111011;
    localparam logic [5:0] V_DONEER = 6'b111101;

    rst_seq_ctrl #(
        .NUM_DOMAINS(3),
        .HOLD_CYCLES(8),
        .GAP_CYCLES(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SW_RST_REQ(SW_RST_REQ),
        .DOM_ACK(DOM_ACK),
        .BLK_RST_N(BLK_RST_N),
        .RST_DONE(RST_DONE),
        .BUSY(BUSY),
        .ERR(ERR)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge counter: value N after the Nth rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: on every output change (outside reset) pop and compare.
    always @(negedge CLK) begin
        logic [5:0] cur;
        exp_t       e;
        cur = {BLK_RST_N, RST_DONE, BUSY, ERR};
        if (!RST) begin
            last = cur;
        end else if (cur !== last) begin
            last = cur;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_change: edge %0d value %b, no change queued", cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.val !== cur) begin
                    fails++;
                    $display("[TB] FAIL seq_event: got %b at edge %0d, required %b at edge %0d",
                             cur, cyc, e.val, e.at);
                end
            end
        end
    end

    task automatic applyStimulus(input logic sw, input logic [2:0] ack);
        SW_RST_REQ = sw;
        DOM_ACK    = ack;
    endtask

    task automatic pushExp(input int at, input logic [5:0] val);
        exp_t e;
        e.at  = at;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expv);
        logic [5:0] cur;
        cur = {BLK_RST_N, RST_DONE, BUSY, ERR};
        tests++;
        if (cur !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %b, required %b", name, cur, expv);
        end
    endtask

    // Bounded wait until the monitor has consumed every queued change.
    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s: %0d queued changes never seen, required 0", name, q.size());
            q.delete();
        end
    endtask

    // Queue the standard all-acks-high release pattern after a reference edge.
    task automatic pushSeq(input int ref_edge, input int off0);
        pushExp(ref_edge + off0,      V_REL0);
        pushExp(ref_edge + off0 + 4,  V_REL1);
        pushExp(ref_edge + off0 + 8,  V_REL2);
        pushExp(ref_edge + off0 + 12, V_DONE);
    endtask

    // Assert RST between edges, check reset values at once, release later.
    task automatic pulseReset(input string name, output int base);
        RST = 1'b0;
        #1;
        checkOutput(name, V_HOLD);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST  = 1'b1;
        base = cyc;
    endtask

    initial begin
        int base;
        int s;
        int l;

        RST = 1'b0;
        applyStimulus(1'b0, 3'b111);
        @(posedge CLK);
        #2;
        checkOutput("reset_values", V_HOLD);

        // Case 1: power-up ordering, acks always high.
        @(posedge CLK);
        #2;
        RST  = 1'b1;
        base = cyc;
        pushSeq(base, 9);
        waitDrain("powerup", 60);

        // Case 4: one-cycle soft request while DONE; timing repeats from edge s.
        applyStimulus(1'b1, 3'b111);
        s = cyc + 1;
        pushExp(s, V_HOLD);
        pushSeq(s, 8);
        @(posedge CLK);
        #2;
        applyStimulus(1'b0, 3'b111);
        waitDrain("soft_in_done", 60);

        // Case 5: soft request held 5 cycles while BLK_RST_N = 011.
        applyStimulus(1'b1, 3'b111);
        s = cyc + 1;
        pushExp(s, V_HOLD);
        pushExp(s + 8, V_REL0);
        pushExp(s + 12, V_REL1);
        @(posedge CLK);
        #2;
        applyStimulus(1'b0, 3'b111);
        while (cyc < s + 13) begin
            @(posedge CLK);
            #2;
        end
        applyStimulus(1'b1, 3'b111);
        pushExp(s + 14, V_HOLD);
        repeat (5) @(posedge CLK);
        #2;
        applyStimulus(1'b0, 3'b111);
        l = s + 18;
        pushSeq(l, 8);
        waitDrain("soft_held", 80);

        // Case 3: DOM_ACK[1] stuck low forces a timeout release with ERR.
        applyStimulus(1'b1, 3'b101);
        s = cyc + 1;
        pushExp(s, V_HOLD);
        pushExp(s + 8, V_REL0);
        pushExp(s + 12, V_REL1);
        pushExp(s + 76, V_TOREL2);
        pushExp(s + 80, V_DONEER);
        @(posedge CLK);
        #2;
        applyStimulus(1'b0, 3'b101);
        waitDrain("timeout", 150);

        // Case 2: RST from DONE (clears sticky ERR), then DOM_ACK[0] late.
        applyStimulus(1'b0, 3'b110);
        pulseReset("async_from_done", base);
        pushExp(base + 9, V_REL0);
        while (cyc < base + 20) begin
            @(posedge CLK);
            #2;
        end
        applyStimulus(1'b0, 3'b111);
        pushExp(base + 21, V_REL1);
        pushExp(base + 25, V_REL2);
        pushExp(base + 29, V_DONE);
        waitDrain("late_ack", 60);

        // Case 6: RST asserted between edges while in WAIT(1).
        pulseReset("async_pre", base);
        pushExp(base + 9, V_REL0);
        pushExp(base + 13, V_REL1);
        while (cyc < base + 14) begin
            @(posedge CLK);
            #2;
        end
        waitDrain("pre_abort", 10);
        pulseReset("async_mid_wait", base);
        pushSeq(base, 9);
        waitDrain("restart_after_rst", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer for the dual-clock system. It releases per-domain reset requests in a fixed order: domain 0 first, then domain 1, and so on.
- Each request feeds that domain's reset synchronizer. The controller waits for that domain's acknowledgement before releasing the next one.
- It supports a software-triggered full re-reset and reports completion, busy and timeout status.
- It sits in the always-on reference clock domain, ahead of all per-domain reset synchronizers.

Parameters:
- NUM_DOMAINS, 3, number of sequenced reset domains (2..8).
- HOLD_CYCLES, 8, CLK cycles all domain resets stay asserted after reset exit or a soft request (>=1).
- GAP_CYCLES, 4, minimum CLK cycles between consecutive releases (>=1).
- TIMEOUT_CYCLES, 64, CLK cycles to wait for an ack before forcing progress (>GAP_CYCLES).

Ports:
- CLK  in  1  controller clock.
- RST  in  1  reset, asynchronous, active-low.
- SW_RST_REQ  in  1  soft reset request, level-sampled on CLK.
- DOM_ACK  in  NUM_DOMAINS  per-domain "reset released" ack. Each bit is already synchronized to CLK.
- BLK_RST_N  out  NUM_DOMAINS  per-domain reset request, active-low, registered.
- RST_DONE  out  1  all domains released and sequence complete.
- BUSY  out  1  sequence in progress.
- ERR  out  1  sticky; at least one ack timeout occurred in the current sequence.

Behaviour:
- Reset values (RST low, asynchronous): BLK_RST_N=0 (all bits), RST_DONE=0, BUSY=1, ERR=0, state=HOLD, counter=0, domain index=0.
- States:
  - HOLD: count HOLD_CYCLES edges with all BLK_RST_N=0. On the edge that completes the count, set BLK_RST_N[0]=1, clear the counter, and go to WAIT with idx=0.
  - WAIT(idx): increment the counter every edge.
    - Advance when the counter is >=GAP_CYCLES-1 and DOM_ACK[idx]=1 is sampled. This gives at least GAP_CYCLES edges from the release of idx to the next release.
    - If the counter reaches TIMEOUT_CYCLES-1 with no ack, set ERR=1 and advance anyway.
    - Advance means: if idx<NUM_DOMAINS-1, set BLK_RST_N[idx+1]=1, increment idx, clear the counter. Otherwise go to DONE.
  - DONE: RST_DONE=1, BUSY=0. All BLK_RST_N bits stay 1.
- Release timing: BLK_RST_N[0] rises on the (HOLD_CYCLES+1)th rising CLK edge after RST deasserts. The first edge loads HOLD with the counter at 0.
- Release order: bits rise strictly in index order. Once released, a bit stays 1 until RST or a soft request.
- SW_RST_REQ sampled 1 in any state:
  - On that edge: all BLK_RST_N=0, RST_DONE=0, BUSY=1, ERR=0, counter=0, idx=0, state=HOLD.
  - A request held high keeps restarting HOLD. The sequence begins only after the request drops.
- Priority on the same edge: SW_RST_REQ > ack-advance > timeout.
- DOM_ACK bits for indices other than idx are ignored.
- DOM_ACK[idx] high before GAP_CYCLES elapse does not shorten the gap.
- If a DOM_ACK bit for an already-released domain falls later, no action is taken.
- RST asserted mid-sequence aborts immediately to the reset values.
- Counter width: clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1). The counter must not wrap.
- All outputs are registered, with no combinational path from any input to any output.

Test Plan (defaults NUM_DOMAINS=3, HOLD=8, GAP=4, TIMEOUT=64):
1. Power-up ordering with acks always high:
   - Stimulus: deassert RST.
   - Required: BLK_RST_N goes 001 at edge 9, 011 at edge 13, 111 at edge 17. RST_DONE=1 and BUSY=0 at edge 21. ERR=0.
2. Late ack:
   - Stimulus: DOM_ACK[0] rises at edge 20.
   - Required: BLK_RST_N[1] rises at edge 21. The later spacing is unchanged. ERR=0.
3. Timeout:
   - Stimulus: DOM_ACK[1] held at 0.
   - Required: BLK_RST_N[2] rises 64 edges after BLK_RST_N[1]. ERR=1 from that edge. RST_DONE still asserts.
4. Soft reset while in DONE:
   - Stimulus: one-cycle SW_RST_REQ.
   - Required: at the next edge BLK_RST_N=000, RST_DONE=0, BUSY=1, ERR=0. The full case-1 timing repeats, referenced to that edge.
5. Soft reset mid-sequence and held:
   - Stimulus: SW_RST_REQ at 1 for 5 cycles, asserted while BLK_RST_N=011.
   - Required: BLK_RST_N=000 immediately. BLK_RST_N[0] rises 8 edges after the last edge at which the request was sampled high.
6. Async reset mid-WAIT:
   - Stimulus: RST low between edges.
   - Required: outputs take their reset values with no clock edge needed. On release, the sequence restarts as in case 1.
